mr_bus_initiator: RTL and testbench
===================================

// Module: mr_bus_initiator
// PURPOSE
//  Bus initiator (master) for the 8-bit memory-mapped register bus (writeb/endereco/datain/dataout).
//  Accepts single commands on a valid/ready port: WRITE, READ or read-modify-write ADD.
//  Sequences each command onto the bus and returns one response pulse per command.
//  Sits between a controller or testbench and the register responder holding addresses 120/121.
// PARAMETERS
//  BASE_ADDR  120  first mapped bus address
//  NUM_REGS   2    number of mapped addresses; valid range BASE_ADDR..BASE_ADDR+NUM_REGS-1
//  IDLE_ADDR  0    address driven on endereco when the bus is idle (must be unmapped)
// PORTS
//  clk        in   1  clock
//  rst        in   1  asynchronous reset, active-low
//  cmd_valid  in   1  command present
//  cmd_ready  out  1  initiator can accept a command
//  cmd_op     in   2  00=WRITE, 01=READ, 10=ADD (RMW), 11=illegal
//  cmd_addr   in   8  target bus address
//  cmd_wdata  in   8  write data (WRITE) or addend (ADD)
//  rsp_valid  out  1  one-cycle response pulse
//  rsp_rdata  out  8  read data (READ, ADD: value before update); 0 for WRITE or error
//  rsp_err    out  1  with rsp_valid: address out of range or illegal op
//  txn_count  out  8  count of successfully completed commands, wraps 255->0
//  writeb     out  1  bus write strobe
//  endereco   out  8  bus address
//  datain     out  8  bus write data
//  dataout    in   8  bus read data (combinational from responder)
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE; cmd_ready=0 while rst=0, 1 after release;
//   rsp_valid=0, rsp_rdata=0, rsp_err=0, txn_count=0, writeb=0, endereco=IDLE_ADDR, datain=0.
//  All outputs are registered or decoded from state registers only; no path from cmd_* to bus.
//  Accept: cmd_valid & cmd_ready at a rising edge; cmd_addr/op/wdata latched into addr_q/op_q/wd_q.
//  cmd_ready=1 only in IDLE. No pipelining: one command in flight.
//  States:
//   IDLE: bus idle. Accept -> ERR if op=11 or addr outside range; WR if WRITE; RD if READ/ADD.
//   RD:   writeb=0, endereco=addr_q. At end of cycle rd_q<=dataout.
//         If ADD: wd_q<=dataout+wd_q (mod 256, carry dropped) -> WR; else -> RSP.
//   WR:   writeb=1, endereco=addr_q, datain=wd_q for exactly one cycle -> RSP.
//   RSP:  rsp_valid=1, rsp_err=0, rsp_rdata=rd_q (0 for WRITE); txn_count+1; bus idle -> IDLE.
//   ERR:  rsp_valid=1, rsp_err=1, rsp_rdata=0; txn_count unchanged; bus untouched -> IDLE.
//  Latency, accept edge to rsp_valid cycle: WRITE 2, READ 2, ADD 3, error 1 cycles.
//  Throughput: next accept possible in the RSP/ERR cycle's following IDLE cycle.
//  rsp_valid has no back-pressure; it is high for exactly one cycle per accepted command.
//  rsp_rdata/rsp_err hold their last value until the next response.
//  Bus is idle (writeb=0, endereco=IDLE_ADDR, datain=0) in IDLE, RSP and ERR.
//  cmd_valid while not ready: ignored; command inputs may change freely.
//  Reset mid-command: abandoned without response; writeb drops at once, so no partial write.
//  ADD is not atomic against other bus masters; only this initiator drives the bus.
// TESTING (with register responder attached, addr 120/121)
//  1 Reset: rst=0 then 1 -> all outputs at reset values; cmd_ready=1 the first cycle after release.
//  2 WRITE 120,0x5A then READ 120 -> write rsp 2 cycles after accept, rdata=0, err=0;
//    read rsp 2 cycles after accept, rdata=0x5A; txn_count=2.
//  3 WRITE 121,0xF0 then ADD 121,0x20 -> ADD rsp 3 cycles after accept, rdata=0xF0;
//    READ 121 returns 0x10 (wrap).
//  4 READ 122 and op=11 to 120 -> rsp_err=1 one cycle after accept, rdata=0; writeb never 1;
//    txn_count unchanged.
//  5 Hold cmd_valid=1 with back-to-back commands -> exactly one writeb pulse per WRITE/ADD;
//    cmd_ready=0 from accept until IDLE; one rsp per command.
//  6 Assert rst during ADD's WR cycle -> writeb=0 immediately; no rsp_valid;
//    txn_count=0; next READ 121 returns 0 (responder also reset).

Source files
------------

// File: rtl/mr_bus_initiator_if.sv
// Command/response handshake plus 8-bit register-bus signals for mr_bus_initiator.
// The master modport is the initiator's view. The slave modport is the view of
// whatever drives commands and answers the bus.
interface mr_bus_initiator_if;
  // command port
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [7:0] cmd_addr;
  logic [7:0] cmd_wdata;
  // response port
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       rsp_err;
  logic [7:0] txn_count;
  // register bus
  logic       writeb;
  logic [7:0] endereco;
  logic [7:0] datain;
  logic [7:0] dataout;

  modport master (
    input  cmd_valid, cmd_op, cmd_addr, cmd_wdata, dataout,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err, txn_count,
           writeb, endereco, datain
  );

  modport slave (
    output cmd_valid, cmd_op, cmd_addr, cmd_wdata, dataout,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, txn_count,
           writeb, endereco, datain
  );
endinterface

// File: rtl/mr_bus_initiator.sv
// Bus initiator for the 8-bit writeb/endereco/datain/dataout register bus.
// It accepts WRITE, READ and read-modify-write ADD commands one at a time and
// issues exactly one response pulse for each accepted command.
module mr_bus_initiator #(
  parameter int unsigned BASE_ADDR = 120,
  parameter int unsigned NUM_REGS  = 2,
  parameter int unsigned IDLE_ADDR = 0
) (
  input  logic               clk,
  input  logic               rst,
  mr_bus_initiator_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_WR,
    S_RSP,
    S_ERR
  } state_t;

  typedef enum logic [1:0] {
    OP_WRITE = 2'b00,
    OP_READ  = 2'b01,
    OP_ADD   = 2'b10,
    OP_ILL   = 2'b11
  } op_t;

  state_t     r_state;
  state_t     w_next;
  op_t        r_op;
  logic [7:0] r_addr;
  logic [7:0] r_wd;
  logic [7:0] r_rd;
  logic [7:0] r_rsp_rdata;
  logic       r_rsp_err;
  logic [7:0] r_txn;

  logic       w_accept;
  logic       w_in_range;
  logic       w_bad_cmd;
  logic       w_cmd_ready;

  // Address decode uses 9 bits so that BASE_ADDR+NUM_REGS cannot wrap.
  assign w_in_range  = ({1'b0, bus.cmd_addr} >= 9'(BASE_ADDR)) &&
                       ({1'b0, bus.cmd_addr} <  9'(BASE_ADDR + NUM_REGS));
  assign w_bad_cmd   = (op_t'(bus.cmd_op) == OP_ILL) || !w_in_range;
  // The FSM sits in IDLE while reset is held, so ready is also gated by rst.
  assign w_cmd_ready = rst && (r_state == S_IDLE);
  assign w_accept    = bus.cmd_valid && w_cmd_ready;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  // Next-state decode
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (w_bad_cmd)                             w_next = S_ERR;
          else if (op_t'(bus.cmd_op) == OP_WRITE)    w_next = S_WR;
          else                                       w_next = S_RD;
        end
      end
      S_RD:    w_next = (r_op == OP_ADD) ? S_WR : S_RSP;
      S_WR:    w_next = S_RSP;
      S_RSP:   w_next = S_IDLE;
      S_ERR:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Command capture and read/modify data path
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_op   <= OP_WRITE;
      r_addr <= '0;
      r_wd   <= '0;
      r_rd   <= '0;
    end else begin
      if (w_accept) begin
        r_op   <= op_t'(bus.cmd_op);
        r_addr <= bus.cmd_addr;
        r_wd   <= bus.cmd_wdata;
      end
      if (r_state == S_RD) begin
        r_rd <= bus.dataout;
        if (r_op == OP_ADD) r_wd <= bus.dataout + r_wd;
      end
    end
  end

  // Response data is loaded on the edge into RSP/ERR and held until the next response.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      if (r_state == S_RD && r_op != OP_ADD) begin
        r_rsp_rdata <= bus.dataout;
        r_rsp_err   <= 1'b0;
      end else if (r_state == S_WR) begin
        r_rsp_rdata <= (r_op == OP_ADD) ? r_rd : '0;
        r_rsp_err   <= 1'b0;
      end else if (r_state == S_IDLE && w_next == S_ERR) begin
        r_rsp_rdata <= '0;
        r_rsp_err   <= 1'b1;
      end
    end
  end

  // Completed-command counter, stepped as RSP is left, wraps naturally
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                  r_txn <= '0;
    else if (r_state == S_RSP) r_txn <= r_txn + 8'd1;
  end

  assign bus.cmd_ready = w_cmd_ready;
  assign bus.rsp_valid = (r_state == S_RSP) || (r_state == S_ERR);
  assign bus.rsp_rdata = r_rsp_rdata;
  assign bus.rsp_err   = r_rsp_err;
  assign bus.txn_count = r_txn;

  // Bus outputs decode from state only. An asynchronous reset drops writeb immediately.
  assign bus.writeb    = (r_state == S_WR);
  assign bus.endereco  = (r_state == S_RD || r_state == S_WR) ? r_addr : 8'(IDLE_ADDR);
  assign bus.datain    = (r_state == S_WR) ? r_wd : '0;

endmodule

// File: tb/tb_mr_bus_initiator.sv
// Self-checking bench for mr_bus_initiator with a two-register responder at 120/121.
module tb_mr_bus_initiator;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mr_bus_initiator_if bus();

  mr_bus_initiator #(
    .BASE_ADDR(120),
    .NUM_REGS (2),
    .IDLE_ADDR(0)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Register responder: two 8-bit registers, reset together with the initiator
  logic [7:0] resp_mem [2];
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      resp_mem[0] <= '0;
      resp_mem[1] <= '0;
    end else if (bus.writeb && (bus.endereco == 8'd120 || bus.endereco == 8'd121)) begin
      resp_mem[bus.endereco[0]] <= bus.datain;
    end
  end
  assign bus.dataout = (bus.endereco == 8'd120) ? resp_mem[0] :
                       (bus.endereco == 8'd121) ? resp_mem[1] : 8'h00;

  int errors = 0;
  int checks = 0;

  task automatic chkb(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%02h expected 0x%02h", name, act, exp);
    end
  endtask

  task automatic chki(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Transaction-level reference: register contents and completed count
  logic [7:0] m_regs [2];
  logic [7:0] m_cnt;

  task automatic model_reset();
    m_regs[0] = '0;
    m_regs[1] = '0;
    m_cnt     = '0;
  endtask

  task automatic predict(input logic [1:0] op, input logic [7:0] a, input logic [7:0] wd,
                         output logic e, output logic [7:0] rd, output int lat,
                         output int wr, output logic [7:0] wdat);
    int idx;
    logic [7:0] old;
    e = 1'b0; rd = '0; lat = 1; wr = 0; wdat = '0;
    if (op == 2'b11 || a < 8'd120 || a > 8'd121) begin
      e = 1'b1;
    end else begin
      idx = int'(a) - 120;
      old = m_regs[idx];
      case (op)
        2'b00: begin lat = 2; wr = 1; wdat = wd; m_regs[idx] = wd; end
        2'b01: begin lat = 2; rd = old; end
        default: begin
          lat = 3; wr = 1; rd = old;
          wdat = old + wd;
          m_regs[idx] = wdat;
        end
      endcase
      m_cnt = m_cnt + 8'd1;
    end
  endtask

  // Issue one command, entered and left near a falling edge.
  task automatic do_cmd(input logic [1:0] op, input logic [7:0] a, input logic [7:0] wd,
                        input bit hold, input bit use_tab, input logic t_err,
                        input logic [7:0] t_rdata, input int t_lat);
    logic e; logic [7:0] rd; int lat; int wr; logic [7:0] wdat;
    int k; int n; int wrn; int bad_ready; int bad_bus;
    predict(op, a, wd, e, rd, lat, wr, wdat);
    bus.cmd_op = op; bus.cmd_addr = a; bus.cmd_wdata = wd; bus.cmd_valid = 1'b1;
    k = 0;
    while (!bus.cmd_ready && k < 20) begin @(negedge clk); k++; end
    chkb("ready_before_accept", bus.cmd_ready, 1'b1);
    @(negedge clk);
    bus.cmd_valid = hold;
    bus.cmd_op = 2'($urandom); bus.cmd_addr = 8'($urandom); bus.cmd_wdata = 8'($urandom);
    n = 1; wrn = 0; bad_ready = 0; bad_bus = 0;
    while (1) begin
      if (bus.writeb) begin
        wrn++;
        if (bus.endereco != a || bus.datain != wdat) bad_bus++;
      end
      if (bus.cmd_ready) bad_ready++;
      if (bus.rsp_valid || n >= 8) break;
      @(negedge clk);
      n++;
    end
    chkb("rsp_seen", bus.rsp_valid, 1'b1);
    chki("latency", n, lat);
    chk8("rsp_rdata", bus.rsp_rdata, rd);
    chkb("rsp_err", bus.rsp_err, e);
    chki("writeb_pulses", wrn, wr);
    chki("write_addr_data", bad_bus, 0);
    chki("ready_low_in_flight", bad_ready, 0);
    chkb("bus_idle_writeb", bus.writeb, 1'b0);
    chk8("bus_idle_addr", bus.endereco, 8'd0);
    chk8("bus_idle_data", bus.datain, 8'd0);
    if (use_tab) begin
      chki("tab_latency", n, t_lat);
      chk8("tab_rdata", bus.rsp_rdata, t_rdata);
      chkb("tab_err", bus.rsp_err, t_err);
    end
    @(negedge clk);
    chkb("rsp_single_cycle", bus.rsp_valid, 1'b0);
    chkb("ready_after", bus.cmd_ready, 1'b1);
    chk8("txn_count", bus.txn_count, m_cnt);
    chk8("rdata_held", bus.rsp_rdata, rd);
    chkb("err_held", bus.rsp_err, e);
  endtask

  typedef struct {
    logic [1:0] op;
    logic [7:0] addr;
    logic [7:0] wd;
    logic       exp_err;
    logic [7:0] exp_rdata;
    int         exp_lat;
  } vec_t;

  vec_t vecs [10];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int k;
    vecs[0] = '{2'b00, 8'd120, 8'h5A, 1'b0, 8'h00, 2};
    vecs[1] = '{2'b01, 8'd120, 8'h00, 1'b0, 8'h5A, 2};
    vecs[2] = '{2'b00, 8'd121, 8'hF0, 1'b0, 8'h00, 2};
    vecs[3] = '{2'b10, 8'd121, 8'h20, 1'b0, 8'hF0, 3};
    vecs[4] = '{2'b01, 8'd121, 8'h00, 1'b0, 8'h10, 2};
    vecs[5] = '{2'b01, 8'd122, 8'h00, 1'b1, 8'h00, 1};
    vecs[6] = '{2'b11, 8'd120, 8'h77, 1'b1, 8'h00, 1};
    vecs[7] = '{2'b00, 8'd119, 8'h33, 1'b1, 8'h00, 1};
    vecs[8] = '{2'b10, 8'd120, 8'hA6, 1'b0, 8'h5A, 3};
    vecs[9] = '{2'b01, 8'd120, 8'h00, 1'b0, 8'h00, 2};

    bus.cmd_valid = 1'b0; bus.cmd_op = '0; bus.cmd_addr = '0; bus.cmd_wdata = '0;
    model_reset();

    // Reset values while held and right after release
    repeat (3) @(negedge clk);
    chkb("rst_ready", bus.cmd_ready, 1'b0);
    chkb("rst_rsp_valid", bus.rsp_valid, 1'b0);
    chk8("rst_rdata", bus.rsp_rdata, 8'h00);
    chkb("rst_err", bus.rsp_err, 1'b0);
    chk8("rst_txn", bus.txn_count, 8'h00);
    chkb("rst_writeb", bus.writeb, 1'b0);
    chk8("rst_addr", bus.endereco, 8'h00);
    chk8("rst_datain", bus.datain, 8'h00);
    rst = 1'b1;
    #1;
    chkb("ready_after_release", bus.cmd_ready, 1'b1);
    chkb("rsp_after_release", bus.rsp_valid, 1'b0);
    @(negedge clk);

    // Directed vectors
    for (int i = 0; i < 10; i++)
      do_cmd(vecs[i].op, vecs[i].addr, vecs[i].wd, 1'b0, 1'b1,
             vecs[i].exp_err, vecs[i].exp_rdata, vecs[i].exp_lat);

    // Randomized commands, cmd_valid sometimes held high back to back
    for (int i = 0; i < 60; i++) begin
      logic [7:0] a;
      case ($urandom_range(0, 5))
        0:       a = 8'd119;
        1, 2:    a = 8'd120;
        3, 4:    a = 8'd121;
        default: a = 8'($urandom);
      endcase
      do_cmd(2'($urandom_range(0, 3)), a, 8'($urandom), bit'($urandom_range(0, 1)),
             1'b0, 1'b0, 8'h00, 0);
    end
    bus.cmd_valid = 1'b0;
    @(negedge clk);

    // Reset during the write cycle of an ADD abandons it without a response
    bus.cmd_op = 2'b10; bus.cmd_addr = 8'd121; bus.cmd_wdata = 8'h33; bus.cmd_valid = 1'b1;
    k = 0;
    while (!bus.cmd_ready && k < 20) begin @(negedge clk); k++; end
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    k = 0;
    while (!bus.writeb && k < 5) begin @(negedge clk); k++; end
    chkb("add_wr_cycle_seen", bus.writeb, 1'b1);
    #1 rst = 1'b0;
    #1;
    chkb("midrst_writeb", bus.writeb, 1'b0);
    chk8("midrst_addr", bus.endereco, 8'h00);
    chkb("midrst_rsp", bus.rsp_valid, 1'b0);
    chk8("midrst_txn", bus.txn_count, 8'h00);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    chkb("midrst_ready", bus.cmd_ready, 1'b1);
    k = 0;
    repeat (3) begin
      @(negedge clk);
      if (bus.rsp_valid) k++;
    end
    chki("midrst_no_rsp", k, 0);
    do_cmd(2'b01, 8'd121, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
